lr_shift_stream: RTL and testbench

//   Streaming front-end for the left-right bit shifter. Accepts shift commands
//   (bits, amount, direction) over a valid/ready interface and queues them in a

---
 rtl/lr_shift_stream_pkg.sv | 19 +
 rtl/lr_shift_stream_core.sv | 20 ++
 rtl/lr_shift_stream.sv | 93 +++++++++
 tb/tb_lr_shift_stream.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lr_shift_stream_pkg.sv
// Shared types and helpers for the left-right shift stream and its shifter core.
package lr_shift_stream_pkg;

   typedef enum logic {
      SHIFT_LEFT  = 1'b0,
      SHIFT_RIGHT = 1'b1
   } shift_dir_e;

   // Ceiling log2 for parameter-derived widths; 64-bit compare avoids sign wrap at bit 31.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((longint'(1) << i) < longint'(value)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/lr_shift_stream_core.sv
// Combinational logical shifter: zero-fill left or right shift, result truncated to width.
module lr_shift_core
   import lr_shift_stream_pkg::*;
#(
   parameter int width   = 8,
   parameter int shift_w = clog2(width)
) (
   input  logic [width-1:0]   data,
   input  logic [shift_w-1:0] shift,
   input  shift_dir_e         dir,
   output logic [width-1:0]   result
);

   always_comb begin
      result = '0;
      if (dir == SHIFT_LEFT) result = data << shift;
      else                   result = data >> shift;
   end

endmodule

// File: rtl/lr_shift_stream.sv
// Command FIFO feeding a shifter core into a registered valid/ready output; 2-cycle minimum latency.
// A stalled output holds its data and lets the FIFO fill until in_ready drops at full.
module lr_shift_stream
   import lr_shift_stream_pkg::*;
#(
   parameter int width = 8,
   parameter int depth = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [width-1:0]         in_bits,
   input  logic [clog2(width)-1:0]  in_shift,
   input  logic                     in_dir,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [width-1:0]         out_bits,
   output logic [clog2(depth):0]    count
);

   localparam int shift_w = clog2(width);
   localparam int ptr_w   = clog2(depth);
   localparam logic [ptr_w:0] full_count = (ptr_w + 1)'(depth);

   typedef struct packed {
      logic [width-1:0]   bits;
      logic [shift_w-1:0] shift;
      shift_dir_e         dir;
   } cmd_t;

   cmd_t               fifo_mem [depth];
   cmd_t               head;
   logic [ptr_w-1:0]   wr_ptr;
   logic [ptr_w-1:0]   rd_ptr;
   logic               push;
   logic               pop;
   logic               out_free;
   logic [width-1:0]   shifted;

   // Full blocks input even when the output is draining this cycle.
   assign in_ready = (count != full_count);
   assign push     = in_valid & in_ready;
   assign out_free = ~out_valid | out_ready;
   assign pop      = (count != '0) & out_free;
   assign head     = fifo_mem[rd_ptr];

   lr_shift_core #(
      .width   (width),
      .shift_w (shift_w)
   ) u_core (
      .data   (head.bits),
      .shift  (head.shift),
      .dir    (head.dir),
      .result (shifted)
   );

   // Storage needs no reset: count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= '{bits: in_bits, shift: in_shift, dir: shift_dir_e'(in_dir)};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_bits  <= '0;
      end else if (pop) begin
         out_valid <= 1'b1;
         out_bits  <= shifted;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lr_shift_stream.sv
// Directed bench for lr_shift_stream with a result-order scoreboard and a short random stall phase.
module tb_lr_shift_stream;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_bits;
   logic [2:0] in_shift;
   logic       in_dir;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_bits;
   logic [2:0] count;

   int         total;
   int         bad;
   int         pushes;
   logic [7:0] exp_next;
   logic [7:0] q[$];

   lr_shift_stream #(.width(8), .depth(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bits   (in_bits),
      .in_shift  (in_shift),
      .in_dir    (in_dir),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bits  (out_bits),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_shift(input logic [7:0] b, input logic [2:0] s, input logic d);
      return d ? (b >> s) : (b << s);
   endfunction

   task automatic set_cmd(input logic [7:0] b, input logic [2:0] s, input logic d, input logic [7:0] e);
      in_valid = 1'b1;
      in_bits  = b;
      in_shift = s;
      in_dir   = d;
      exp_next = e;
   endtask

   // Record the handshakes that the coming edge will perform, then advance one cycle.
   task automatic step();
      logic hi;
      logic ho;
      hi = rst && in_valid && in_ready;
      ho = rst && out_valid && out_ready;
      if (ho) begin
         chk("sb_has_entry", 32'(q.size() != 0), 1);
         if (q.size() != 0) chk("out_order", out_bits, q.pop_front());
      end
      if (hi) begin
         q.push_back(exp_next);
         pushes++;
      end
      @(posedge clk);
      #1;
   endtask

   logic [7:0] v_bits [8];
   logic [2:0] v_shift[8];
   logic       v_dir  [8];
   logic [7:0] v_exp  [8];

   initial begin
      total = 0; bad = 0; pushes = 0;
      rst = 1'b1; in_valid = 1'b0; in_bits = '0; in_shift = '0; in_dir = 1'b0;
      out_ready = 1'b0; exp_next = '0;
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Reset state
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_bits", out_bits, 0);
      chk("rst_count", count, 0);
      chk("rst_in_ready", in_ready, 1);

      // 1. Single command: B4 << 2 = D0, visible two edges after accept
      out_ready = 1'b1;
      set_cmd(8'hB4, 3'd2, 1'b0, 8'hD0);
      step();
      in_valid = 1'b0;
      chk("t1_count_after_push", count, 1);
      chk("t1_not_yet_valid", out_valid, 0);
      step();
      chk("t1_out_valid", out_valid, 1);
      chk("t1_out_bits", out_bits, 8'hD0);
      chk("t1_count_zero", count, 0);
      step();
      chk("t1_consumed", out_valid, 0);

      // 2. Eight back-to-back commands with out_ready high
      v_bits  = '{8'h81, 8'h01, 8'hF0, 8'h0F, 8'hA5, 8'hA5, 8'hFF, 8'h3C};
      v_shift = '{3'd1,  3'd7,  3'd4,  3'd4,  3'd3,  3'd3,  3'd7,  3'd0};
      v_dir   = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
      v_exp   = '{8'h40, 8'h80, 8'h0F, 8'hF0, 8'h28, 8'h14, 8'h01, 8'h3C};
      for (int i = 0; i < 8; i++) begin
         set_cmd(v_bits[i], v_shift[i], v_dir[i], v_exp[i]);
         chk("t2_in_ready", in_ready, 1);
         if (i >= 1) chk("t2_count", count, 1);
         if (i >= 2) chk("t2_one_per_cycle", out_valid, 1);
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      chk("t2_drained_valid", out_valid, 0);
      chk("t2_drained_count", count, 0);
      chk("t2_sb_empty", q.size(), 0);

      // 3. Backpressure: six offered, five accepted
      out_ready = 1'b0;
      v_bits  = '{8'h11, 8'h22, 8'h80, 8'h55, 8'hC3, 8'h12, 8'h00, 8'h00};
      v_shift = '{3'd1,  3'd1,  3'd7,  3'd0,  3'd4,  3'd1,  3'd0,  3'd0};
      v_dir   = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};
      v_exp   = '{8'h22, 8'h44, 8'h01, 8'h55, 8'h30, 8'h24, 8'h00, 8'h00};
      for (int i = 0; i < 6; i++) begin
         set_cmd(v_bits[i], v_shift[i], v_dir[i], v_exp[i]);
         if (i < 5) begin
            chk("t3_accepting", in_ready, 1);
            step();
         end else begin
            chk("t3_full_in_ready", in_ready, 0);
            chk("t3_full_count", count, 4);
         end
      end
      in_valid = 1'b0;
      step();
      step();
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_bits", out_bits, 8'h22);
      chk("t3_hold_count", count, 4);
      out_ready = 1'b1;
      repeat (6) step();
      chk("t3_drained_sb", q.size(), 0);
      chk("t3_drained_count", count, 0);
      chk("t3_drained_valid", out_valid, 0);

      // 4. Full FIFO while a push is offered and the output drains
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_cmd(8'(i + 1), 3'd1, 1'b0, 8'(2 * (i + 1)));
         step();
      end
      set_cmd(8'h40, 3'd1, 1'b0, 8'h80);
      out_ready = 1'b1;
      chk("t4_full_count", count, 4);
      chk("t4_full_in_ready", in_ready, 0);
      step();
      chk("t4_after_pop_count", count, 3);
      chk("t4_after_pop_in_ready", in_ready, 1);
      chk("t4_head_kept", out_bits, 8'h04);
      step();
      chk("t4_push_pop_count", count, 3);
      in_valid = 1'b0;
      repeat (6) step();
      chk("t4_drained_sb", q.size(), 0);
      chk("t4_drained_count", count, 0);

      // 5. Reset asserted mid-stream
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_cmd(8'h10 + 8'(i), 3'd0, 1'b0, 8'h10 + 8'(i));
         step();
      end
      in_valid = 1'b0;
      chk("t5_pre_count", count, 3);
      chk("t5_pre_valid", out_valid, 1);
      rst = 1'b0;
      #2;
      chk("t5_rst_valid", out_valid, 0);
      chk("t5_rst_bits", out_bits, 0);
      chk("t5_rst_count", count, 0);
      q.delete();
      @(posedge clk);
      #1 rst = 1'b1;
      out_ready = 1'b1;
      set_cmd(8'hFF, 3'd3, 1'b1, 8'h1F);
      step();
      in_valid = 1'b0;
      step();
      chk("t5_post_valid", out_valid, 1);
      chk("t5_post_bits", out_bits, 8'h1F);
      step();

      // 6a. Zero shift passes data through in both directions
      set_cmd(8'h5A, 3'd0, 1'b0, 8'h5A);
      step();
      set_cmd(8'hC3, 3'd0, 1'b1, 8'hC3);
      step();
      in_valid = 1'b0;
      chk("t6_shift0_left", out_bits, 8'h5A);
      step();
      chk("t6_shift0_right", out_bits, 8'hC3);
      step();

      // 6b. Pointer wrap under random stalls
      pushes = 0;
      for (int c = 0; c < 300 && pushes < 16; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_bits   = 8'($urandom);
         in_shift  = 3'($urandom_range(0, 7));
         in_dir    = 1'($urandom_range(0, 1));
         exp_next  = ref_shift(in_bits, in_shift, in_dir);
         out_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (8) step();
      chk("t6_enough_pushes", 32'(pushes >= 12), 1);
      chk("t6_sb_empty", q.size(), 0);
      chk("t6_count_zero", count, 0);
      chk("t6_valid_low", out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
